dmac_engine: RTL and testbench
==============================

// Module: dmac_engine
// PURPOSE
//  Single-channel DMA copy engine acting as AXI master. Copies byte_len_i bytes from
//  src_addr_i to dst_addr_i with read-burst-then-write-burst sequencing through an
//  internal beat buffer. Drives the AXI_AW/W/B/AR/R channel interfaces that the
//  AXI_SLAVE memory model serves in the DMAC bench.
// PARAMETERS
//  ADDR_WIDTH  32            address width of araddr/awaddr and src/dst registers
//  DATA_WIDTH  `AXI_DATA_WIDTH  beat width; fixed at 32 in this block (4 bytes/beat)
//  ID_WIDTH    `AXI_ID_WIDTH    width of arid/awid
//  MAX_BEATS   16            max beats per burst = buffer depth (arlen/awlen <= 15)
//  TX_ID       0             constant arid/awid driven on every request
// PORTS
//  clk         in   1           clock, all state on rising edge
//  rst_n       in   1           synchronous active-low reset
//  start_i     in   1           1-cycle start pulse; sampled only in S_IDLE
//  src_addr_i  in   ADDR_WIDTH  source byte address, 4-byte aligned
//  dst_addr_i  in   ADDR_WIDTH  destination byte address, 4-byte aligned
//  byte_len_i  in   16          bytes to copy; bits[1:0] ignored
//  done_o      out  1           1 while in S_IDLE
//  aw_ch       master  AXI_AW_CH  awid/awaddr/awlen/awsize/awburst/awvalid out, awready in
//  w_ch        master  AXI_W_CH   wid/wdata/wstrb/wlast/wvalid out, wready in
//  b_ch        master  AXI_B_CH   bid/bresp/bvalid in, bready out
//  ar_ch       master  AXI_AR_CH  arid/araddr/arlen/arsize/arburst/arvalid out, arready in
//  r_ch        master  AXI_R_CH   rid/rdata/rresp/rlast/rvalid in, rready out
// BEHAVIOUR
//  - Reset: state S_IDLE, done_o=1, arvalid=awvalid=wvalid=rready=bready=0,
//    src/dst/cnt/beat counters cleared. Buffer contents don't-care.
//  - Constants: arsize=awsize=2, arburst=awburst=INCR(1), wstrb=4'hF, ids=TX_ID.
//  - beats = min(cnt[15:2], MAX_BEATS); arlen=awlen=beats-1 (held stable per burst).
//  - S_IDLE: on start_i latch src,dst,cnt={byte_len_i[15:2],2'b00}; cnt==0 -> stay
//    S_IDLE (done_o never drops); else -> S_RREQ next cycle. start_i elsewhere ignored.
//  - S_RREQ: arvalid=1, araddr=src. arvalid/addr/len held until arready. On
//    arvalid&arready -> S_RDATA, beat idx=0.
//  - S_RDATA: rready=1. Each rvalid beat writes buf[idx]=rdata, idx++. On beat
//    idx==beats-1 -> S_WREQ. Beat count is authoritative; rlast/rresp not checked.
//  - S_WREQ: awvalid=1, awaddr=dst, awlen=beats-1; hold until awready -> S_WDATA, idx=0.
//  - S_WDATA: wvalid=1, wdata=buf[idx], wlast=(idx==beats-1). Data held while
//    wready=0. On wvalid&wready idx++; last beat -> S_WRESP.
//  - S_WRESP: bready=1. On bvalid: src+=4*beats, dst+=4*beats, cnt-=4*beats;
//    new cnt==0 -> S_IDLE (done_o=1 next cycle) else -> S_RREQ. bresp ignored.
//  - AW issued only after full read burst; no AR/AW overlap, one burst in flight.
//  - Address arithmetic wraps modulo 2^ADDR_WIDTH; no 4KB-boundary splitting.
//  - Latency, 1-beat copy, zero-wait slave: AR at cycle 1 after start; done_o
//    returns no earlier than cycle after B handshake.
//  - rst_n low mid-transfer: next edge all valids/readies 0, S_IDLE, done_o=1;
//    outstanding AXI traffic abandoned (bench resets slave too).
// TESTING
//  1 Reset held 3 cycles -> done_o=1, arvalid/awvalid/wvalid/rready/bready all 0.
//  2 src=0x0100 dst=0x0800 len=64 -> one AR (araddr=0x100,arlen=15), one AW
//    (awaddr=0x800,awlen=15), wlast on 16th beat; mem[0x800..0x83F]==mem[0x100..0x13F].
//  3 len=68 -> bursts arlen=15 @0x100 then arlen=0 @0x140; AW @0x800 then @0x840.
//  4 len=0 (and len=3) with start -> no AR/AW ever, done_o stays 1.
//  5 Slave AWREADY_DELAY=5, AR2R_DELAY=50, start re-pulsed while busy -> valids
//    and addr/data stable until handshake; second start ignored; one copy only.
//  6 rst_n low 1 cycle during S_WDATA -> next cycle all valids 0, done_o=1; new
//    start len=16 completes with correct destination data.

Source files
------------

// File: rtl/dmac_engine.sv
// Single-channel AXI DMA copy engine: reads one burst into a local beat buffer,
// then writes it out, repeating until the requested byte count is copied.
module dmac_engine #(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ID_WIDTH   = 4,
    parameter int                  MAX_BEATS  = 16,
    parameter logic [ID_WIDTH-1:0] TX_ID      = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [15:0]           byte_len_i,
    output logic                  done_o,
    // AW channel
    output logic [ID_WIDTH-1:0]   awid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    // W channel
    output logic [ID_WIDTH-1:0]   wid,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    // B channel
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AR channel
    output logic [ID_WIDTH-1:0]   arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    // R channel
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int IDX_W  = $clog2(MAX_BEATS);
    localparam int BEAT_W = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RREQ  = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WDATA = 3'd4,
        S_WRESP = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] buf_q [MAX_BEATS];
    logic [DATA_WIDTH-1:0] buf_d [MAX_BEATS];

    logic [13:0]           words_s;
    logic [BEAT_W-1:0]     beats_s;
    logic [IDX_W-1:0]      last_idx_s;
    logic [ADDR_WIDTH-1:0] step_addr_s;
    logic [15:0]           step_cnt_s;
    logic                  unused_ok;

    // Burst sizing: capped at buffer depth, stable for a whole burst since cnt only moves in S_WRESP.
    always_comb begin
        words_s = cnt_q[15:2];
        if (words_s >= 14'(MAX_BEATS)) begin
            beats_s = BEAT_W'(MAX_BEATS);
        end else begin
            beats_s = words_s[BEAT_W-1:0];
        end
        last_idx_s  = IDX_W'(beats_s - BEAT_W'(1));
        step_addr_s = ADDR_WIDTH'({beats_s, 2'b00});
        step_cnt_s  = 16'({beats_s, 2'b00});
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d = src_addr_i;
                    dst_d = dst_addr_i;
                    cnt_d = {byte_len_i[15:2], 2'b00};
                    if (byte_len_i[15:2] != 14'd0) begin
                        state_d = S_RREQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RREQ: begin
                if (arready) begin
                    state_d = S_RDATA;
                    idx_d   = '0;
                end else begin
                    state_d = S_RREQ;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    buf_d[idx_q] = rdata;
                    if (idx_q == last_idx_s) begin
                        state_d = S_WREQ;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_WREQ: begin
                if (awready) begin
                    state_d = S_WDATA;
                    idx_d   = '0;
                end else begin
                    state_d = S_WREQ;
                end
            end
            S_WDATA: begin
                if (wready) begin
                    if (idx_q == last_idx_s) begin
                        state_d = S_WRESP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = S_WDATA;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    src_d = src_q + step_addr_s;
                    dst_d = dst_q + step_addr_s;
                    cnt_d = cnt_q - step_cnt_s;
                    if (cnt_q == step_cnt_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RREQ;
                    end
                end else begin
                    state_d = S_WRESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= 16'd0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Beat buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign done_o  = (state_q == S_IDLE);

    assign arid    = TX_ID;
    assign araddr  = src_q;
    assign arlen   = 8'(last_idx_s);
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign arvalid = (state_q == S_RREQ);
    assign rready  = (state_q == S_RDATA);

    assign awid    = TX_ID;
    assign awaddr  = dst_q;
    assign awlen   = 8'(last_idx_s);
    assign awsize  = 3'd2;
    assign awburst = 2'b01;
    assign awvalid = (state_q == S_WREQ);

    assign wid     = TX_ID;
    assign wdata   = buf_q[idx_q];
    assign wstrb   = 4'hF;
    assign wlast   = (state_q == S_WDATA) && (idx_q == last_idx_s);
    assign wvalid  = (state_q == S_WDATA);
    assign bready  = (state_q == S_WRESP);

    // Response ids/status and rlast are not used: the beat count drives sequencing.
    assign unused_ok = ^{bid, bresp, rid, rresp, rlast};

endmodule

// File: tb/tb_dmac_engine.sv
// Directed bench for dmac_engine with a small behavioural AXI slave memory.
module tb_dmac_engine;

    logic        clk = 1'b0;
    logic        rst_n, start_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [15:0] byte_len_i;
    logic        done_o;
    logic [3:0]  awid, wid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    dmac_engine dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .src_addr_i(src_addr_i),
        .dst_addr_i(dst_addr_i), .byte_len_i(byte_len_i), .done_o(done_o),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA5C3_0000 + i * 32'h0003_0007;
    endfunction

    // ---------------- slave memory model ----------------
    logic [31:0] mem [0:1023];
    int          aw_delay = 0, ar2r_delay = 0;
    bit          w_stall = 1'b0, log_clr;

    bit          ar_hs, aw_hs, w_hs, r_hs, b_hs, rst_cap, clr_cap, cap_wlast;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [7:0]  cap_arlen, cap_awlen;
    bit          ar_wait_prev, aw_wait_prev, w_wait_prev;
    logic [31:0] ar_addr_prev, aw_addr_prev, wdata_prev;
    int          stab_err;

    // Handshake capture and valid/payload stability monitor at the active edge.
    always @(posedge clk) begin
        ar_hs = arvalid && arready;
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        r_hs  = rvalid && rready;
        b_hs  = bvalid && bready;
        rst_cap = rst_n;
        clr_cap = log_clr;
        cap_araddr = araddr; cap_arlen = arlen;
        cap_awaddr = awaddr; cap_awlen = awlen;
        cap_wdata  = wdata;  cap_wlast = wlast;
        if (log_clr) begin
            stab_err = 0;
        end else begin
            if (ar_wait_prev && (!arvalid || araddr != ar_addr_prev)) stab_err++;
            if (aw_wait_prev && (!awvalid || awaddr != aw_addr_prev)) stab_err++;
            if (w_wait_prev && (!wvalid || wdata != wdata_prev)) stab_err++;
        end
        ar_wait_prev = rst_n && arvalid && !arready;
        aw_wait_prev = rst_n && awvalid && !awready;
        w_wait_prev  = rst_n && wvalid && !wready;
        ar_addr_prev = araddr; aw_addr_prev = awaddr; wdata_prev = wdata;
    end

    int          aw_wcnt, rd_wait, rd_left, wr_left, wbeats, ar_count, aw_count;
    logic [31:0] rd_addr, wr_addr;
    logic [31:0] ar_addr_log [0:7], aw_addr_log [0:7];
    logic [7:0]  ar_len_log [0:7], aw_len_log [0:7];
    int          wlast_beat [0:7];
    bit          w_toggle;

    // Slave responses, driven on the falling edge for the next rising edge.
    always @(negedge clk) begin
        bid = 4'd0; rid = 4'd0; bresp = 2'b00; rresp = 2'b00;
        if (clr_cap) begin
            ar_count = 0; aw_count = 0;
            for (int i = 0; i < 1024; i++) mem[i] = pat(i);
            for (int k = 0; k < 8; k++) begin
                ar_addr_log[k] = 32'd0; aw_addr_log[k] = 32'd0;
                ar_len_log[k] = 8'd0; aw_len_log[k] = 8'd0; wlast_beat[k] = 0;
            end
        end
        if (!rst_cap) begin
            arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            rdata = 32'd0; bvalid = 1'b0; aw_wcnt = 0; rd_left = 0; rd_wait = 0;
            wr_left = 0; wbeats = 0; w_toggle = 1'b0;
        end else begin
            arready = 1'b1;
            if (ar_hs) begin
                if (ar_count < 8) begin
                    ar_addr_log[ar_count] = cap_araddr; ar_len_log[ar_count] = cap_arlen;
                end
                ar_count++;
                rd_addr = cap_araddr; rd_left = int'(cap_arlen) + 1; rd_wait = ar2r_delay;
            end
            if (r_hs) begin
                rd_addr += 32'd4; rd_left--;
            end
            if (rd_left > 0 && rd_wait == 0) begin
                rvalid = 1'b1; rdata = mem[rd_addr[11:2]]; rlast = (rd_left == 1);
            end else begin
                rvalid = 1'b0; rlast = 1'b0;
                if (rd_wait > 0) rd_wait--;
            end
            if (aw_hs) begin
                if (aw_count < 8) begin
                    aw_addr_log[aw_count] = cap_awaddr; aw_len_log[aw_count] = cap_awlen;
                end
                aw_count++;
                wr_addr = cap_awaddr; wr_left = int'(cap_awlen) + 1; wbeats = 0;
            end
            if (awvalid) begin
                awready = (aw_wcnt >= aw_delay); aw_wcnt++;
            end else begin
                awready = 1'b0; aw_wcnt = 0;
            end
            if (b_hs) bvalid = 1'b0;
            if (w_hs) begin
                mem[wr_addr[11:2]] = cap_wdata; wr_addr += 32'd4; wbeats++; wr_left--;
                if (cap_wlast && aw_count >= 1 && aw_count <= 8 && wlast_beat[aw_count-1] == 0)
                    wlast_beat[aw_count-1] = wbeats;
                if (wr_left == 0) bvalid = 1'b1;
            end
            if (w_stall) begin
                w_toggle = !w_toggle; wready = w_toggle;
            end else begin
                wready = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic int data_errs(input logic [31:0] s, input logic [31:0] d, input int words);
        int e = 0;
        for (int k = 0; k < words; k++)
            if (mem[(d[11:2] + k) % 1024] !== pat((s[11:2] + k) % 1024)) e++;
        return e;
    endfunction

    task automatic clear_slave();
        log_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    logic first_arvalid;
    logic [31:0] first_araddr;

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        src_addr_i = s; dst_addr_i = d; byte_len_i = l; start_i = 1'b1;
        @(posedge clk);
        #1;
        first_arvalid = arvalid; first_araddr = araddr;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, done_o, 1'b1);
    endtask

    int drops;

    initial begin
        rst_n = 1'b0; start_i = 1'b0; src_addr_i = 32'd0; dst_addr_i = 32'd0;
        byte_len_i = 16'd0; log_clr = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_done", done_o, 1'b1);
        check_val("rst_arvalid", arvalid, 1'b0);
        check_val("rst_awvalid", awvalid, 1'b0);
        check_val("rst_wvalid", wvalid, 1'b0);
        check_val("rst_rready", rready, 1'b0);
        check_val("rst_bready", bready, 1'b0);
        log_clr = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        // single-beat copy: AR must appear in the cycle right after start
        clear_slave();
        pulse_start(32'h0000_0400, 32'h0000_0E00, 16'd4);
        check_val("lat_arvalid_c1", first_arvalid, 1'b1);
        check_val("lat_araddr", first_araddr, 32'h0000_0400);
        wait_done("lat_done", 500);
        check_val("lat_arlen", ar_len_log[0], 8'd0);
        check_val("lat_data", data_errs(32'h400, 32'hE00, 1), 0);

        // 64 bytes: one full 16-beat burst
        clear_slave();
        pulse_start(32'h0000_0100, 32'h0000_0800, 16'd64);
        wait_done("t2_done", 1000);
        check_val("t2_ar_count", ar_count, 1);
        check_val("t2_araddr", ar_addr_log[0], 32'h0000_0100);
        check_val("t2_arlen", ar_len_log[0], 8'd15);
        check_val("t2_aw_count", aw_count, 1);
        check_val("t2_awaddr", aw_addr_log[0], 32'h0000_0800);
        check_val("t2_awlen", aw_len_log[0], 8'd15);
        check_val("t2_wlast_beat", wlast_beat[0], 16);
        check_val("t2_data", data_errs(32'h100, 32'h800, 16), 0);

        // 68 bytes: 16-beat burst followed by a 1-beat burst
        clear_slave();
        pulse_start(32'h0000_0100, 32'h0000_0800, 16'd68);
        wait_done("t3_done", 1000);
        check_val("t3_ar_count", ar_count, 2);
        check_val("t3_arlen0", ar_len_log[0], 8'd15);
        check_val("t3_araddr1", ar_addr_log[1], 32'h0000_0140);
        check_val("t3_arlen1", ar_len_log[1], 8'd0);
        check_val("t3_awaddr0", aw_addr_log[0], 32'h0000_0800);
        check_val("t3_awaddr1", aw_addr_log[1], 32'h0000_0840);
        check_val("t3_awlen1", aw_len_log[1], 8'd0);
        check_val("t3_wlast_beat1", wlast_beat[1], 1);
        check_val("t3_data", data_errs(32'h100, 32'h800, 17), 0);

        // zero-length and sub-word lengths never issue traffic
        clear_slave();
        drops = 0;
        pulse_start(32'h0000_0100, 32'h0000_0800, 16'd0);
        for (int i = 0; i < 20; i++) begin
            if (!done_o) drops++;
            @(negedge clk);
        end
        pulse_start(32'h0000_0100, 32'h0000_0800, 16'd3);
        for (int i = 0; i < 20; i++) begin
            if (!done_o) drops++;
            @(negedge clk);
        end
        check_val("t4_done_drops", drops, 0);
        check_val("t4_ar_count", ar_count, 0);
        check_val("t4_aw_count", aw_count, 0);

        // slow slave, stalled W, and a start pulse while busy
        clear_slave();
        aw_delay = 5; ar2r_delay = 50; w_stall = 1'b1;
        pulse_start(32'h0000_0300, 32'h0000_0C00, 16'd8);
        repeat (10) @(negedge clk);
        pulse_start(32'h0000_0000, 32'h0000_0F00, 16'd64);
        wait_done("t5_done", 2000);
        repeat (20) @(negedge clk);
        check_val("t5_ar_count", ar_count, 1);
        check_val("t5_aw_count", aw_count, 1);
        check_val("t5_araddr", ar_addr_log[0], 32'h0000_0300);
        check_val("t5_awaddr", aw_addr_log[0], 32'h0000_0C00);
        check_val("t5_awlen", aw_len_log[0], 8'd1);
        check_val("t5_stable", stab_err, 0);
        check_val("t5_data", data_errs(32'h300, 32'hC00, 2), 0);
        check_val("t5_no_second", mem[32'hF00 >> 2], pat(32'hF00 >> 2));
        aw_delay = 0; ar2r_delay = 0; w_stall = 1'b0;

        // reset in the middle of the write burst, then a fresh copy
        clear_slave();
        pulse_start(32'h0000_0200, 32'h0000_0A00, 16'd64);
        for (int i = 0; i < 200 && !wvalid; i++) @(negedge clk);
        check_val("t6_in_wdata", wvalid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("t6_rst_done", done_o, 1'b1);
        check_val("t6_rst_wvalid", wvalid, 1'b0);
        check_val("t6_rst_arvalid", arvalid, 1'b0);
        check_val("t6_rst_awvalid", awvalid, 1'b0);
        check_val("t6_rst_readies", {30'd0, rready, bready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_slave();
        pulse_start(32'h0000_0200, 32'h0000_0A00, 16'd16);
        wait_done("t6_done", 500);
        check_val("t6_aw_count", aw_count, 1);
        check_val("t6_awlen", aw_len_log[0], 8'd3);
        check_val("t6_data", data_errs(32'h200, 32'hA00, 4), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
